irq_arbiter: RTL

Interrupt arbiter between the memory-mapped devices (timer, key, switch) and the processor core's system registers. It captures rising edges on the three device IRQ lines into per-source pending bits and picks one pending source by fixed priority. It then presents a single IRQ line plus the device number that is loaded into IDN, and holds both stable until the core acknowledges. A short post-acknowledge holdoff lets the pipeline flush before the next request is presented.

---
 rtl/irq_pkg.sv | 30 +++
 rtl/irq_edge_capture.sv | 58 +++++
 rtl/irq_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt arbiter: source indices, the arbiter
// state encoding, the holdoff counter width and the fixed-priority picker.
// -----------------------------------------------------------------------------
package irq_pkg;

  localparam int NUM_SRC = 3;
  localparam int SRC_T   = 0;
  localparam int SRC_K   = 1;
  localparam int SRC_SW  = 2;

  localparam int CNT_W   = 4;

  typedef logic [1:0] src_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Fixed priority: timer > key > switch. Only meaningful when |pend.
  function automatic src_idx_t pick_src(input logic [NUM_SRC-1:0] pend);
    if (pend[SRC_T])      return src_idx_t'(SRC_T);
    else if (pend[SRC_K]) return src_idx_t'(SRC_K);
    else                  return src_idx_t'(SRC_SW);
  endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// -----------------------------------------------------------------------------
// irq_edge_capture
// Per-source rising-edge detector with a pending bit and a sticky overrun flag.
// Ports:
//   i_clk          system clock
//   i_rst_n        synchronous active-low reset
//   i_in           level request from the device
//   i_clr_pending  arbiter took this source (ACK while presented)
//   i_clr_ovr      clear the overrun flag
//   o_pending      a captured edge is waiting for service
//   o_ovr          an edge arrived while already pending (sticky)
// -----------------------------------------------------------------------------
module irq_edge_capture
  import irq_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  input  logic i_clr_pending,
  input  logic i_clr_ovr,
  output logic o_pending,
  output logic o_ovr
);

  logic r_prev;
  logic r_pending;
  logic r_ovr;
  logic w_edge;

  assign w_edge = i_in & ~r_prev;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // Loading the live input means a line held high across reset is not
      // seen as a fresh edge afterwards.
      r_prev    <= i_in;
      r_pending <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_prev <= i_in;

      // A new edge beats a same-cycle clear: the new request must survive.
      if (w_edge)             r_pending <= 1'b1;
      else if (i_clr_pending) r_pending <= 1'b0;

      // An edge that coincides with the clear of its own pending is a fresh
      // request, not an overrun. A set beats a same-cycle flag clear.
      if (w_edge && r_pending && !i_clr_pending) r_ovr <= 1'b1;
      else if (i_clr_ovr)                        r_ovr <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_ovr     = r_ovr;

endmodule

// File: rtl/irq_arbiter.sv
// -----------------------------------------------------------------------------
// irq_arbiter
// Captures rising edges on the timer/key/switch IRQ lines, presents the
// highest-priority pending source to the core on IRQ/IDN, holds it until ACK,
// then keeps IRQ low for ACK_HOLD cycles so the pipeline can flush.
// Ports:
//   CLK      system clock
//   LOCK     synchronous active-low reset
//   IRQ_T    timer request (level)
//   IRQ_K    key request (level)
//   IRQ_SW   switch request (level)
//   ACK      one-cycle pulse: core took the interrupt
//   CLR_OVR  one-cycle pulse: clear all overrun flags
//   IRQ      registered interrupt request to the core
//   IDN      registered device number of the presented source
//   OVR      sticky overrun flags {sw, key, timer}
// -----------------------------------------------------------------------------
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int IDN_TIMER = 1,
  parameter int IDN_KEY   = 2,
  parameter int IDN_SW    = 3,
  parameter int ACK_HOLD  = 2
) (
  input  logic             CLK,
  input  logic             LOCK,
  input  logic             IRQ_T,
  input  logic             IRQ_K,
  input  logic             IRQ_SW,
  input  logic             ACK,
  input  logic             CLR_OVR,
  output logic             IRQ,
  output logic [DBITS-1:0] IDN,
  output logic [2:0]       OVR
);

  function automatic logic [DBITS-1:0] idn_of(input src_idx_t s);
    case (s)
      src_idx_t'(SRC_T): return DBITS'(IDN_TIMER);
      src_idx_t'(SRC_K): return DBITS'(IDN_KEY);
      default:           return DBITS'(IDN_SW);
    endcase
  endfunction

  state_t             r_state;
  src_idx_t           r_sel;
  logic [DBITS-1:0]   r_idn;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_irq;

  state_t             w_next_state;
  src_idx_t           w_next_sel;
  logic [DBITS-1:0]   w_next_idn;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               w_ack_take;

  logic [NUM_SRC-1:0] w_in;
  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_ovr;
  logic [NUM_SRC-1:0] w_clr_pending;

  assign w_in = {IRQ_SW, IRQ_K, IRQ_T};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign w_clr_pending[i] = w_ack_take && (r_sel == src_idx_t'(i));

    irq_edge_capture u_cap (
      .i_clk         (CLK),
      .i_rst_n       (LOCK),
      .i_in          (w_in[i]),
      .i_clr_pending (w_clr_pending[i]),
      .i_clr_ovr     (CLR_OVR),
      .o_pending     (w_pending[i]),
      .o_ovr         (w_ovr[i])
    );
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    w_next_state = r_state;
    w_next_sel   = r_sel;
    w_next_idn   = r_idn;
    w_next_cnt   = r_cnt;
    w_ack_take   = 1'b0;

    case (r_state)
      IDLE: begin
        if (|w_pending) begin
          w_next_sel   = pick_src(w_pending);
          w_next_idn   = idn_of(w_next_sel);
          w_next_state = PRESENT;
        end
      end
      PRESENT: begin
        // sel/IDN stay frozen here; later higher-priority edges wait.
        if (ACK) begin
          w_ack_take   = 1'b1;
          w_next_cnt   = CNT_W'(ACK_HOLD - 1);
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (r_cnt == '0) w_next_state = IDLE;
        else             w_next_cnt   = r_cnt - CNT_W'(1);
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!LOCK) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_idn   <= '0;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_sel   <= w_next_sel;
      r_idn   <= w_next_idn;
      r_cnt   <= w_next_cnt;
      // Registered alongside the state so IRQ is high exactly in PRESENT.
      r_irq   <= (w_next_state == PRESENT);
    end
  end

  assign IRQ = r_irq;
  assign IDN = r_idn;
  assign OVR = w_ovr;

endmodule
